// File: rtl/stack_driver.sv
// rtl/stack_driver.sv - command sequencer that turns move/backtrack/clear/drain requests into LIFO stack strobes
module stack_driver #(
    parameter bit INVERT_POP = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [1:0] cmd_dir,
    output logic       stk_push,
    output logic       stk_pop,
    output logic       stk_init,
    output logic [1:0] stk_data_in,
    input  logic [1:0] stk_data_out,
    input  logic       stk_full,
    input  logic       stk_empty,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_dir,
    output logic       out_last,
    output logic       err,
    output logic [8:0] depth
);

    typedef enum logic [2:0] {
        IDLE,
        PUSH,
        POP_REQ,
        POP_WAIT,
        OUT,
        CLEAR
    } state_t;

    localparam logic [1:0] OP_PUSH  = 2'b00;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_DRAIN = 2'b11;

    state_t state;
    state_t state_next;
    logic   drain;
    logic   accept;

    assign accept = cmd_valid & cmd_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Strobes, err and out_valid are decoded from state so a reset removes them at once.
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
        stk_init   = 1'b0;
        err        = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_PUSH:  state_next = PUSH;
                        OP_CLEAR: state_next = CLEAR;
                        default:  state_next = POP_REQ;
                    endcase
                end
            end
            PUSH: begin
                if (stk_full) begin
                    err = 1'b1;
                end else begin
                    stk_push = 1'b1;
                end
                state_next = IDLE;
            end
            POP_REQ: begin
                if (stk_empty) begin
                    // An empty drain is a legal no-op; only a single pop is a fault.
                    err        = ~drain;
                    state_next = IDLE;
                end else begin
                    stk_pop    = 1'b1;
                    state_next = POP_WAIT;
                end
            end
            POP_WAIT: begin
                state_next = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = (drain && !stk_empty) ? POP_REQ : IDLE;
                end
            end
            CLEAR: begin
                stk_init   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stk_data_in <= 2'b00;
            drain       <= 1'b0;
        end else if (accept) begin
            stk_data_in <= cmd_dir;
            drain       <= (cmd_op == OP_DRAIN);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            depth <= 9'd0;
        end else if (stk_init) begin
            depth <= 9'd0;
        end else if (stk_push) begin
            depth <= depth + 9'd1;
        end else if (stk_pop) begin
            depth <= depth - 9'd1;
        end
    end

    // stk_empty already reflects the post-pop pointer here, so it marks the final drain element.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_dir  <= 2'b00;
            out_last <= 1'b0;
        end else if (state == POP_WAIT) begin
            out_dir  <= (INVERT_POP && !drain) ? (stk_data_out ^ 2'b10) : stk_data_out;
            out_last <= drain & stk_empty;
        end
    end

endmodule

// File: tb/tb_stack_driver.sv
// tb/tb_stack_driver.sv - directed self-checking bench for stack_driver with a behavioural LIFO
module tb_stack_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [1:0] cmd_dir;
    logic       stk_push;
    logic       stk_pop;
    logic       stk_init;
    logic [1:0] stk_data_in;
    logic [1:0] stk_data_out;
    logic       stk_full;
    logic       stk_empty;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_dir;
    logic       out_last;
    logic       err;
    logic [8:0] depth;

    int checks = 0;
    int errors = 0;
    int push_cnt = 0;
    int pop_cnt = 0;
    int overlap = 0;

    always #5 clk = ~clk;

    stack_driver #(.INVERT_POP(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_dir      (cmd_dir),
        .stk_push     (stk_push),
        .stk_pop      (stk_pop),
        .stk_init     (stk_init),
        .stk_data_in  (stk_data_in),
        .stk_data_out (stk_data_out),
        .stk_full     (stk_full),
        .stk_empty    (stk_empty),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_dir      (out_dir),
        .out_last     (out_last),
        .err          (err),
        .depth        (depth)
    );

    // Behavioural 256 x 2 LIFO with registered read data
    logic [1:0] mem [0:255];
    logic [8:0] sp;
    logic [1:0] rd;

    assign stk_full     = (sp == 9'd256);
    assign stk_empty    = (sp == 9'd0);
    assign stk_data_out = rd;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp <= 9'd0;
            rd <= 2'b00;
        end else if (stk_init) begin
            sp <= 9'd0;
        end else if (stk_push && !stk_full) begin
            sp <= sp + 9'd1;
        end else if (stk_pop && !stk_empty) begin
            rd <= mem[sp[7:0] - 8'd1];
            sp <= sp - 9'd1;
        end
    end

    always @(posedge clk) begin
        if (stk_push && !stk_full) mem[sp[7:0]] <= stk_data_in;
    end

    always @(posedge clk) begin
        if (stk_push) push_cnt <= push_cnt + 1;
        if (stk_pop) pop_cnt <= pop_cnt + 1;
        if ((stk_push & stk_pop) | (stk_push & stk_init) | (stk_pop & stk_init)) overlap <= overlap + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns one #1 after the accepting edge, i.e. inside cycle N+1.
    task automatic issue(input logic [1:0] op, input logic [1:0] dir);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        cmd_op    = op;
        cmd_dir   = dir;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_wait", {31'd0, out_valid}, 32'd1);
    endtask

    logic [1:0] pdirs  [0:2];
    logic [1:0] ddirs  [0:2];
    logic [1:0] xdirs  [0:2];
    logic       xlast  [0:2];

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int p;
        int n;
        logic [1:0] held;
        pdirs = '{2'b01, 2'b10, 2'b11};
        ddirs = '{2'b00, 2'b01, 2'b11};
        xdirs = '{2'b11, 2'b01, 2'b00};
        xlast = '{1'b0, 1'b0, 1'b1};

        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_dir   = 2'b00;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_depth", {23'd0, depth}, 32'd0);
        chk("rst_data_in", {30'd0, stk_data_in}, 32'd0);
        chk("rst_strobes", {29'd0, stk_push, stk_pop, stk_init}, 32'd0);
        chk("rst_err_out", {29'd0, err, out_last, out_dir != 2'b00}, 32'd0);
        rst = 1'b1;

        // Three pushes
        for (int i = 0; i < 3; i++) begin
            issue(2'b00, pdirs[i]);
            @(negedge clk);
            chk("push_strobe", {31'd0, stk_push}, 32'd1);
            chk("push_data", {30'd0, stk_data_in}, {30'd0, pdirs[i]});
            chk("push_err", {31'd0, err}, 32'd0);
            @(negedge clk);
            chk("push_ready_n2", {30'd0, cmd_ready, stk_push}, 32'd2);
        end
        chk("push_depth", {23'd0, depth}, 32'd3);
        chk("push_count", push_cnt, 32'd3);

        // Single inverted pop
        issue(2'b01, 2'b00);
        @(negedge clk);
        chk("pop_strobe_n1", {31'd0, stk_pop}, 32'd1);
        @(negedge clk);
        chk("pop_valid_n2", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("pop_valid_n3", {31'd0, out_valid}, 32'd1);
        chk("pop_dir", {30'd0, out_dir}, 32'd1);
        chk("pop_last", {31'd0, out_last}, 32'd0);
        @(negedge clk);
        chk("pop_ready_n4", {31'd0, cmd_ready}, 32'd1);
        chk("pop_depth", {23'd0, depth}, 32'd2);

        issue(2'b10, 2'b00);
        @(negedge clk);
        chk("clr_init", {31'd0, stk_init}, 32'd1);
        @(negedge clk);
        chk("clr_depth", {23'd0, depth}, 32'd0);
        chk("clr_empty", {31'd0, stk_empty}, 32'd1);

        // Drain three entries with a stalling consumer
        for (int i = 0; i < 3; i++) begin
            issue(2'b00, ddirs[i]);
            @(negedge clk);
        end
        out_ready = 1'b0;
        issue(2'b11, 2'b00);
        for (int i = 0; i < 3; i++) begin
            wait_out();
            chk("drain_dir", {30'd0, out_dir}, {30'd0, xdirs[i]});
            chk("drain_last", {31'd0, out_last}, {31'd0, xlast[i]});
            held = out_dir;
            p = pop_cnt;
            repeat (2) @(negedge clk);
            chk("drain_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("drain_hold_dir", {30'd0, out_dir}, {30'd0, held});
            chk("drain_hold_nopop", pop_cnt, p);
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
        end
        @(negedge clk);
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done_ready", {31'd0, cmd_ready}, 32'd1);
        chk("drain_depth", {23'd0, depth}, 32'd0);
        chk("drain_no_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;

        // Pop and drain on empty
        issue(2'b01, 2'b00);
        @(negedge clk);
        chk("epop_err", {31'd0, err}, 32'd1);
        chk("epop_nopop", {31'd0, stk_pop}, 32'd0);
        @(negedge clk);
        chk("epop_err_clear", {31'd0, err}, 32'd0);
        chk("epop_ready", {30'd0, cmd_ready, out_valid}, 32'd2);
        issue(2'b11, 2'b00);
        @(negedge clk);
        chk("edrain_err", {31'd0, err}, 32'd0);
        chk("edrain_nopop", {31'd0, stk_pop}, 32'd0);
        @(negedge clk);
        chk("edrain_ready", {30'd0, cmd_ready, out_valid}, 32'd2);

        // Fill to 256 then overflow
        for (int i = 0; i < 256; i++) begin
            issue(2'b00, i[1:0]);
            @(negedge clk);
        end
        @(negedge clk);
        chk("full_depth", {23'd0, depth}, 32'd256);
        chk("full_flag", {31'd0, stk_full}, 32'd1);
        issue(2'b00, 2'b01);
        @(negedge clk);
        chk("ovf_err", {31'd0, err}, 32'd1);
        chk("ovf_nopush", {31'd0, stk_push}, 32'd0);
        @(negedge clk);
        chk("ovf_err_clear", {31'd0, err}, 32'd0);
        chk("ovf_depth", {23'd0, depth}, 32'd256);
        issue(2'b10, 2'b00);
        @(negedge clk);
        chk("clr2_init", {31'd0, stk_init}, 32'd1);
        @(negedge clk);
        chk("clr2_depth", {23'd0, depth}, 32'd0);
        chk("clr2_empty", {31'd0, stk_empty}, 32'd1);

        // Reset in the middle of a drain output
        issue(2'b00, 2'b10);
        @(negedge clk);
        out_ready = 1'b0;
        issue(2'b11, 2'b00);
        wait_out();
        chk("rdrain_dir", {30'd0, out_dir}, 32'd2);
        chk("rdrain_last", {31'd0, out_last}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rdrain_valid_drop", {31'd0, out_valid}, 32'd0);
        chk("rdrain_last_drop", {31'd0, out_last}, 32'd0);
        chk("rdrain_err_drop", {31'd0, err}, 32'd0);
        chk("rdrain_depth", {23'd0, depth}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rdrain_ready", {31'd0, cmd_ready}, 32'd1);

        chk("strobe_exclusive", overlap, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
